mem_stage_controller: RTL and testbench
=======================================

Name: mem_stage_controller

Overview:
- Sequences the data-memory access for the instruction held in the EX/MEM pipeline register.
- Converts the load/store control into a valid/ready request plus a response wait on the data-memory port.
- Stalls the upstream pipeline registers until the access completes.
- Returns aligned, extended load data, or a misalignment exception, to the MEM/WB stage.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in RESP before a bus error is raised (used only with MEM_TIMEOUT_EN).
- ADDR_W, 32: data address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_m  in  1  EX/MEM slot holds a live instruction
- mem_read_m  in  1  load
- mem_write_m  in  1  store
- mem_size_m  in  2  mem_size_t: 00 byte, 01 half, 10 word, 11 illegal
- mem_unsigned_m  in  1  zero-extend load (else sign-extend)
- addr_m  in  ADDR_W  byte address (DataMemoryAddress_m)
- wd_m  in  32  store data, in low bits
- flush_m  in  1  kill the MEM-stage instruction (trap/redirect)
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  write enable
- dmem_req_addr  out  ADDR_W  word-aligned address, addr_m with [1:0] forced to 0
- dmem_req_wdata  out  32  store data replicated across lanes
- dmem_req_wstrb  out  4  byte strobes
- dmem_rsp_valid  in  1  response (read data or write ack)
- dmem_rsp_rdata  in  32  read word
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
- rdata_m  out  32  extended load result
- rdata_valid  out  1  rdata_m valid this cycle
- misalign_exc  out  1  one-cycle exception pulse
- bus_err  out  1  one-cycle timeout pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; dmem_req_valid, dmem_req_we, dmem_req_wstrb, rdata_valid, misalign_exc, bus_err, stall_o all 0; rdata_m 0; kill flag cleared.
- op = valid_m & (mem_read_m | mem_write_m) & ~flush_m.
- Misaligned when: half with addr_m[0]=1; word with addr_m[1:0]≠0; size 11.
- States IDLE, REQ, RESP, DONE:
  - IDLE, op & aligned: stall_o=1 (combinational); register address, we, wstrb, wdata, size and unsigned; -> REQ.
  - IDLE, op & misaligned: misalign_exc=1 for that cycle; stall_o=0; no request; stay IDLE.
  - REQ: dmem_req_valid=1 with stable payload until dmem_req_ready; on handshake -> RESP; stall_o=1.
  - RESP: wait for dmem_rsp_valid; capture rdata; -> DONE; stall_o=1.
  - DONE: stall_o=0; rdata_valid=1 for a load unless killed; pipeline advances; -> IDLE unconditionally.
- DONE never re-triggers on the same instruction.
- Minimum latency with ready=1 and response one cycle after handshake: 3 stalled cycles, data in the 4th.
- wstrb: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Load extraction: byte lane addr[1:0]; half lane addr[1]; sign- or zero-extend to 32.
- flush_m in REQ/RESP sets the kill flag. The request is never withdrawn once valid, and the response is still consumed. In DONE, rdata_valid=0; stall behaviour is unchanged. The flag clears in IDLE.
- flush_m in IDLE: no request, no exception.
- dmem_rsp_valid seen in IDLE/REQ/DONE is ignored.
- Reset mid-operation returns to IDLE immediately; any in-flight response is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8+ bit counter, cleared on RESP entry.
  - If TIMEOUT_CYCLES elapse without dmem_rsp_valid: bus_err=1 for one cycle, -> DONE with rdata_valid=0.
- Undefined: no counter; RESP waits indefinitely; bus_err tied 0.

Decomposition:
- Pkg gains mem_size_t enum, mem_state_t enum (IDLE, REQ, RESP, DONE) and a WSTRB_* constant set.
- One combinational sub-module, load_aligner: inputs rdata, addr[1:0], size, unsigned; output 32-bit extended data.

Test Plan:
- Load word addr 0x100, ready=1, rsp next cycle rdata=0xDEADBEEF -> stall_o high 3 cycles; DONE rdata_m=0xDEADBEEF, rdata_valid=1.
- Signed byte load addr 0x203, rdata=0x80FF_FF00 -> rdata_m=0xFFFF_FF80. Same with unsigned=1 -> 0x0000_0080.
- Store half addr 0x302, wd=0x1234, ready low 4 cycles -> req_valid held stable, wstrb=1100, wdata=0x12341234, addr=0x300; stall ends after ack.
- Load word addr 0x101 -> misalign_exc one cycle, dmem_req_valid never asserted, stall_o=0.
- flush_m during RESP, rsp rdata=0x5 -> response consumed, DONE rdata_valid=0, returns IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp -> bus_err pulse after 8 RESP cycles, stall released next cycle; reset asserted in REQ -> req_valid=0 next cycle.

Source files
------------

// File: rtl/mem_stage_controller_pkg.sv
// mem_stage_controller_pkg
// Shared types and constants for the MEM-stage data-memory controller.
//   mem_size_t  : access size encoding carried down the pipeline
//   mem_state_t : controller sequencing states
//   WSTRB_*     : base byte-strobe patterns before lane shifting
// Helper functions compute misalignment, strobes and lane-replicated store data.
package mem_stage_controller_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } mem_state_t;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    // The illegal size encoding is reported as a misalignment so that it
    // never reaches the memory port.
    function automatic logic isMisaligned(input mem_size_t size, input logic [1:0] lsb);
        logic result;
        case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = lsb[0];
            SIZE_WORD: result = |lsb;
            default:   result = 1'b1;
        endcase
        return result;
    endfunction

    // Strobes select the lanes touched by an aligned access.
    function automatic logic [3:0] wstrbFor(input mem_size_t size, input logic [1:0] lsb);
        logic [3:0] result;
        case (size)
            SIZE_BYTE: result = WSTRB_BYTE << lsb;
            SIZE_HALF: result = WSTRB_HALF << lsb;
            SIZE_WORD: result = WSTRB_WORD;
            default:   result = WSTRB_NONE;
        endcase
        return result;
    endfunction

    // Store data sits in the low bits; copying it into every lane lets the
    // strobes alone pick the destination bytes.
    function automatic logic [31:0] replicateStore(input mem_size_t size, input logic [31:0] wd);
        logic [31:0] result;
        case (size)
            SIZE_BYTE: result = {4{wd[7:0]}};
            SIZE_HALF: result = {2{wd[15:0]}};
            default:   result = wd;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_controller_load_aligner.sv
// load_aligner
// Purely combinational: selects the addressed byte/half lane of a read word
// and sign- or zero-extends it to 32 bits.
//   rdata_i    : raw 32-bit word from data memory
//   addr_lsb_i : byte offset within the word
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : extended load result
module load_aligner
    import mem_stage_controller_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lsb_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Lane selection followed by extension; word accesses pass straight through.
    always_comb begin
        byteLane = rdata_i[7:0];
        case (addr_lsb_i)
            2'd0: byteLane = rdata_i[7:0];
            2'd1: byteLane = rdata_i[15:8];
            2'd2: byteLane = rdata_i[23:16];
            2'd3: byteLane = rdata_i[31:24];
            default: byteLane = rdata_i[7:0];
        endcase
        halfLane = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: data_o = {{24{~unsigned_i & byteLane[7]}}, byteLane};
            SIZE_HALF: data_o = {{16{~unsigned_i & halfLane[15]}}, halfLane};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller
// Sequences the data-memory access of the EX/MEM instruction through a
// valid/ready request and a response wait, stalling the upstream pipeline
// until the access completes, then hands aligned load data (or a
// misalignment exception) to MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN adds a RESP timeout that raises a
// one-cycle bus_err and abandons the access after TIMEOUT_CYCLES.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   valid_m, mem_read_m, mem_write_m    : EX/MEM instruction control
//   mem_size_m, mem_unsigned_m          : access size and load extension
//   addr_m, wd_m, flush_m               : byte address, store data, kill
//   dmem_req_*                          : request channel to data memory
//   dmem_rsp_valid, dmem_rsp_rdata      : response channel from data memory
//   stall_o                             : freeze upstream pipeline registers
//   rdata_m, rdata_valid                : extended load result
//   misalign_exc, bus_err               : one-cycle exception pulses
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [1:0]        mem_size_m,
    input  logic              mem_unsigned_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wd_m,
    input  logic              flush_m,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [31:0]       dmem_req_wdata,
    output logic [3:0]        dmem_req_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rsp_rdata,
    output logic              stall_o,
    output logic [31:0]       rdata_m,
    output logic              rdata_valid,
    output logic              misalign_exc,
    output logic              bus_err
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    mem_size_t         size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic              kill_q, kill_d;
    logic [31:0]       rdata_q, rdata_d;
    mem_size_t         sizeM;
    logic              memOp;
    logic [31:0]       alignedData;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeoutHit;
`endif

    assign sizeM = mem_size_t'(mem_size_m);
    assign memOp = valid_m & (mem_read_m | mem_write_m) & ~flush_m;

    // Payload is held in registers so it stays stable for the whole REQ phase
    // even if the EX/MEM inputs wiggle.
    assign dmem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_req_wdata = wdata_q;
    assign dmem_req_we    = (state_q == REQ) & we_q;
    assign dmem_req_wstrb = (state_q == REQ) ? wstrb_q : WSTRB_NONE;
    assign rdata_m        = rdata_q;

    load_aligner u_loadAligner (
        .rdata_i    (dmem_rsp_rdata),
        .addr_lsb_i (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (alignedData)
    );

    // Next-state and output decode. The kill flag remembers a flush that
    // arrives after the request went out: the bus transaction must still
    // complete, only the result is suppressed. DONE always falls back to
    // IDLE so one instruction can never launch two accesses.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wstrb_d        = wstrb_q;
        wdata_d        = wdata_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        kill_d         = kill_q;
        rdata_d        = rdata_q;
        stall_o        = 1'b0;
        dmem_req_valid = 1'b0;
        rdata_valid    = 1'b0;
        misalign_exc   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d          = cnt_q;
        timeoutHit     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (memOp) begin
                    if (isMisaligned(sizeM, addr_m[1:0])) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        addr_d     = addr_m;
                        we_d       = mem_write_m;
                        wstrb_d    = wstrbFor(sizeM, addr_m[1:0]);
                        wdata_d    = replicateStore(sizeM, wd_m);
                        size_d     = sizeM;
                        unsigned_d = mem_unsigned_m;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                stall_o        = 1'b1;
                dmem_req_valid = 1'b1;
                if (flush_m) kill_d = 1'b1;
                if (dmem_req_ready) begin
                    state_d = RESP;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (flush_m) kill_d = 1'b1;
                if (dmem_rsp_valid) begin
                    if (!we_q) rdata_d = alignedData;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeoutHit = 1'b1;
                    kill_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                rdata_valid = ~we_q & ~kill_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    assign bus_err = timeoutHit;
`else
    assign bus_err = 1'b0;
`endif

    // State and payload registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wstrb_q    <= WSTRB_NONE;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            kill_q     <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            kill_q     <= kill_d;
            rdata_q    <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller
// Directed bench for mem_stage_controller: loads of each size and extension,
// a back-pressured half store, misalignment, flushes, stray responses and
// reset mid-request. With MEM_TIMEOUT_EN defined the RESP timeout is also
// exercised using TIMEOUT_CYCLES = 8.
module tb_mem_stage_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        validM, memReadM, memWriteM, memUnsignedM, flushM;
    logic [1:0]  memSizeM;
    logic [31:0] addrM, wdM;
    logic        reqValid, reqReady, reqWe;
    logic [31:0] reqAddr, reqWdata;
    logic [3:0]  reqWstrb;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        stall, rdataValid, misalignExc, busErr;
    logic [31:0] rdataM;

    int errCount   = 0;
    int checkCount = 0;

    mem_stage_controller #(
        .TIMEOUT_CYCLES (8),
        .ADDR_W         (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_m        (validM),
        .mem_read_m     (memReadM),
        .mem_write_m    (memWriteM),
        .mem_size_m     (memSizeM),
        .mem_unsigned_m (memUnsignedM),
        .addr_m         (addrM),
        .wd_m           (wdM),
        .flush_m        (flushM),
        .dmem_req_valid (reqValid),
        .dmem_req_ready (reqReady),
        .dmem_req_we    (reqWe),
        .dmem_req_addr  (reqAddr),
        .dmem_req_wdata (reqWdata),
        .dmem_req_wstrb (reqWstrb),
        .dmem_rsp_valid (rspValid),
        .dmem_rsp_rdata (rspRdata),
        .stall_o        (stall),
        .rdata_m        (rdataM),
        .rdata_valid    (rdataValid),
        .misalign_exc   (misalignExc),
        .bus_err        (busErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        validM       = v;
        memReadM     = rd;
        memWriteM    = wr;
        memSizeM     = size;
        memUnsignedM = uns;
        addrM        = addr;
        wdM          = wd;
        #1;
    endtask

    task automatic runLoad(input string name, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] expAddr, input logic [31:0] rsp, input logic [31:0] expData);
        reqReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, size, uns, addr, 32'h0);
        checkBit({name, " stall idle"}, stall, 1'b1);
        checkBit({name, " no req idle"}, reqValid, 1'b0);
        tick();
        checkBit({name, " req valid"}, reqValid, 1'b1);
        checkOutput({name, " req addr"}, reqAddr, expAddr);
        checkBit({name, " req we"}, reqWe, 1'b0);
        checkBit({name, " stall req"}, stall, 1'b1);
        tick();
        checkBit({name, " stall resp"}, stall, 1'b1);
        checkBit({name, " req dropped"}, reqValid, 1'b0);
        rspValid = 1'b1;
        rspRdata = rsp;
        tick();
        rspValid = 1'b0;
        rspRdata = 32'h0;
        checkBit({name, " stall done"}, stall, 1'b0);
        checkBit({name, " rdata valid"}, rdataValid, 1'b1);
        checkOutput({name, " rdata"}, rdataM, expData);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        checkBit({name, " rdata valid clears"}, rdataValid, 1'b0);
        checkBit({name, " stall back idle"}, stall, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        flushM   = 1'b0;
        reqReady = 1'b0;
        rspValid = 1'b0;
        rspRdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkBit("reset req_valid", reqValid, 1'b0);
        checkBit("reset req_we", reqWe, 1'b0);
        checkOutput("reset wstrb", {28'h0, reqWstrb}, 32'h0);
        checkBit("reset stall", stall, 1'b0);
        checkBit("reset rdata_valid", rdataValid, 1'b0);
        checkBit("reset misalign", misalignExc, 1'b0);
        checkBit("reset bus_err", busErr, 1'b0);
        checkOutput("reset rdata_m", rdataM, 32'h0);
        reset = 1'b0;
        tick();

        $display("[TB] load word 0x100");
        runLoad("lw", 32'h100, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        $display("[TB] byte loads at 0x203");
        runLoad("lb", 32'h203, 2'b00, 1'b0, 32'h200, 32'h80FF_FF00, 32'hFFFF_FF80);
        runLoad("lbu", 32'h203, 2'b00, 1'b1, 32'h200, 32'h80FF_FF00, 32'h0000_0080);

        $display("[TB] stray response in idle");
        rspValid = 1'b1;
        rspRdata = 32'h1234_5678;
        tick();
        rspValid = 1'b0;
        tick();
        checkBit("stray rdata_valid", rdataValid, 1'b0);
        checkBit("stray req_valid", reqValid, 1'b0);
        checkOutput("stray rdata held", rdataM, 32'h0000_0080);

        $display("[TB] half store 0x302 with back-pressure");
        reqReady = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_1234);
        checkBit("sh stall idle", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkBit("sh req valid held", reqValid, 1'b1);
            checkOutput("sh addr", reqAddr, 32'h300);
            checkOutput("sh wstrb", {28'h0, reqWstrb}, 32'h0000_000C);
            checkOutput("sh wdata", reqWdata, 32'h1234_1234);
            checkBit("sh we", reqWe, 1'b1);
            checkBit("sh stall req", stall, 1'b1);
        end
        tick();
        checkBit("sh req still valid", reqValid, 1'b1);
        reqReady = 1'b1;
        tick();
        checkBit("sh stall resp", stall, 1'b1);
        checkBit("sh req dropped", reqValid, 1'b0);
        rspValid = 1'b1;
        tick();
        rspValid = 1'b0;
        checkBit("sh stall done", stall, 1'b0);
        checkBit("sh no rdata_valid", rdataValid, 1'b0);
        checkOutput("sh rdata held", rdataM, 32'h0000_0080);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] misaligned accesses");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        checkBit("mis word exc", misalignExc, 1'b1);
        checkBit("mis word stall", stall, 1'b0);
        tick();
        checkBit("mis word no req", reqValid, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
        checkBit("illegal size exc", misalignExc, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkBit("mis exc clears", misalignExc, 1'b0);
        tick();
        checkBit("mis no req", reqValid, 1'b0);

        $display("[TB] flush in idle");
        flushM = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        checkBit("flush idle stall", stall, 1'b0);
        checkBit("flush idle exc", misalignExc, 1'b0);
        tick();
        checkBit("flush idle no req", reqValid, 1'b0);
        flushM = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] flush during RESP");
        reqReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        tick();
        tick();
        flushM = 1'b1;
        tick();
        flushM   = 1'b0;
        checkBit("flush resp still waiting", stall, 1'b1);
        rspValid = 1'b1;
        rspRdata = 32'h0000_0005;
        tick();
        rspValid = 1'b0;
        checkBit("flush done stall", stall, 1'b0);
        checkBit("flush done no rdata_valid", rdataValid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        checkBit("flush back idle req", reqValid, 1'b0);
        checkBit("flush back idle stall", stall, 1'b0);

        runLoad("lh after flush", 32'h102, 2'b01, 1'b0, 32'h100, 32'hABCD_0000, 32'hFFFF_ABCD);

        $display("[TB] reset during REQ");
        reqReady = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        tick();
        checkBit("rst req valid before", reqValid, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        checkBit("rst req valid after", reqValid, 1'b0);
        checkBit("rst stall after", stall, 1'b0);
        checkOutput("rst rdata_m", rdataM, 32'h0);
        reset = 1'b0;
        tick();
        checkBit("rst stays idle", reqValid, 1'b0);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] RESP timeout");
        reqReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            checkBit("to no bus_err yet", busErr, 1'b0);
            checkBit("to stall waiting", stall, 1'b1);
            tick();
        end
        checkBit("to bus_err pulse", busErr, 1'b1);
        checkBit("to stall at pulse", stall, 1'b1);
        tick();
        checkBit("to bus_err clears", busErr, 1'b0);
        checkBit("to stall released", stall, 1'b0);
        checkBit("to no rdata_valid", rdataValid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
